sisc_ctrl: RTL and testbench

SISC_CTRL -- requirements
Module: sisc_ctrl

---
 rtl/sisc_pkg.sv | 40 ++++
 rtl/sisc_br_cond.sv | 30 +++
 rtl/sisc_ctrl.sv | 150 +++++++++++++++
 tb/tb_sisc_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC control path: width defaults, FSM state
// encodings, opcode constants and ALU operation encodings.
package sisc_pkg;

  // Width defaults used by the modules that import this package.
  localparam int OPC_W_DEF    = 4;
  localparam int MM_W_DEF     = 4;
  localparam int ALU_OP_W_DEF = 2;

  // Controller states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  // Opcodes. HLT is all ones at the default opcode width; the controller
  // matches HLT as all ones at whatever width it is built with.
  localparam int OP_NOOP = 0;
  localparam int OP_LOD  = 1;
  localparam int OP_STR  = 2;
  localparam int OP_SWP  = 3;
  localparam int OP_BRA  = 4;
  localparam int OP_BRR  = 5;
  localparam int OP_BNE  = 6;
  localparam int OP_BNR  = 7;
  localparam int OP_ALU  = 8;
  localparam int OP_HLT  = 15;

  // ALU operation select values.
  localparam int ALU_ADD  = 0;  // register add
  localparam int ALU_ADDI = 1;  // immediate add
  localparam int ALU_ADR  = 2;  // address / swap path, register form
  localparam int ALU_ADRI = 3;  // address / swap path, immediate form

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition evaluation for the SISC controller.
// BRA/BRR branch when any masked status flag is set, or unconditionally
// when the mask is zero. BNE/BNR branch when no masked flag is set.
// Any other opcode is never taken.
module sisc_br_cond
  import sisc_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF,
  parameter int MM_W  = MM_W_DEF
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [MM_W-1:0]  mm,
  input  logic [MM_W-1:0]  stat,
  output logic             taken
);

  logic any_hit;

  // Decide whether the current branch opcode is taken.
  always_comb begin
    any_hit = |(stat & mm);
    taken   = 1'b0;
    if (opcode == OPC_W'(OP_BRA) || opcode == OPC_W'(OP_BRR)) begin
      taken = any_hit || (mm == '0);
    end else if (opcode == OPC_W'(OP_BNE) || opcode == OPC_W'(OP_BNR)) begin
      taken = !any_hit;
    end
  end

endmodule

// File: rtl/sisc_ctrl.sv
// SISC multi-cycle controller. Sequences each instruction through
// FETCH, DECODE, EXECUTE, MEM and WRITEBACK and decodes control strobes.
// Only the state is registered; every strobe is decoded combinationally
// from state, opcode, mm and stat.
// Optional feature: define CTRL_STALL_EN to add the mem_ready input, which
// holds LOD/STR in MEM until the data memory completes.
module sisc_ctrl
  import sisc_pkg::*;
#(
  parameter int OPC_W    = OPC_W_DEF,
  parameter int MM_W     = MM_W_DEF,     // status width equals MM_W
  parameter int ALU_OP_W = ALU_OP_W_DEF
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [MM_W-1:0]     mm,
  input  logic [MM_W-1:0]     stat,
`ifdef CTRL_STALL_EN
  input  logic                mem_ready,
`endif
  output logic                ir_load,
  output logic                pc_write,
  output logic                br_sel,
  output logic                rf_we,
  output logic                rd_sel,
  output logic                dm_we,
  output logic                halted,
  output logic                wb_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          state
);

  state_t              state_reg;
  logic                is_lod;
  logic                is_str;
  logic                is_swp;
  logic                is_alu;
  logic                is_hlt;
  logic                imm;
  logic                taken;
  logic                mem_stall;
  logic [ALU_OP_W-1:0] alu_code;

  assign is_lod = (opcode == OPC_W'(OP_LOD));
  assign is_str = (opcode == OPC_W'(OP_STR));
  assign is_swp = (opcode == OPC_W'(OP_SWP));
  assign is_alu = (opcode == OPC_W'(OP_ALU));
  assign is_hlt = (opcode == '1);
  assign imm    = mm[MM_W-1];

`ifdef CTRL_STALL_EN
  // Only memory-touching instructions wait for the data memory.
  assign mem_stall = !mem_ready && (is_lod || is_str);
`else
  assign mem_stall = 1'b0;
`endif

  sisc_br_cond #(
    .OPC_W (OPC_W),
    .MM_W  (MM_W)
  ) u_br_cond (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (taken)
  );

  // State sequencing; reset wins over everything, including a stall and HALT.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_reg <= ST_START;
    end else begin
      case (state_reg)
        ST_START:     state_reg <= ST_FETCH;
        ST_FETCH:     state_reg <= ST_DECODE;
        ST_DECODE:    state_reg <= is_hlt ? ST_HALT : ST_EXECUTE;
        ST_EXECUTE:   state_reg <= ST_MEM;
        ST_MEM:       state_reg <= mem_stall ? ST_MEM : ST_WRITEBACK;
        ST_WRITEBACK: state_reg <= ST_FETCH;
        ST_HALT:      state_reg <= ST_HALT;
        default:      state_reg <= ST_START;
      endcase
    end
  end

  assign state = state_reg;

  // ALU operation for the current instruction, driven from EXECUTE to WRITEBACK.
  always_comb begin
    alu_code = '0;
    if (is_alu) begin
      alu_code = imm ? ALU_OP_W'(ALU_ADDI) : ALU_OP_W'(ALU_ADD);
    end else if (is_lod || is_str || is_swp) begin
      alu_code = imm ? ALU_OP_W'(ALU_ADRI) : ALU_OP_W'(ALU_ADR);
    end
  end

  // Strobe decode; everything defaults low so NOOP and unknown opcodes are inert.
  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    br_sel   = 1'b0;
    rf_we    = 1'b0;
    rd_sel   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = '0;
    case (state_reg)
      ST_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;   // br_sel stays 0: PC+1
      end
      ST_EXECUTE: begin
        alu_op = alu_code;
        if (taken) begin
          pc_write = 1'b1;
          br_sel   = 1'b1;
        end
      end
      ST_MEM: begin
        alu_op = alu_code;
        if (is_str) begin
          dm_we = 1'b1;    // held for as long as MEM is stalled
        end
        if (is_swp) begin
          rf_we  = 1'b1;   // first half of the swap writes the second register
          rd_sel = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        alu_op = alu_code;
        if (is_alu || is_swp) begin
          rf_we = 1'b1;
        end
        if (is_lod) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Self-checking bench for sisc_ctrl. Expected output vectors are pushed to a
// scoreboard queue as each instruction is set up and popped on the falling
// edge while the DUT walks through the states.
// Vector layout: {state[2:0], ir_load, pc_write, br_sel, rf_we, rd_sel,
//                 dm_we, halted, wb_sel, alu_op[1:0]}
module tb_sisc_ctrl;

  logic       clk = 1'b0;
  logic       rst_f = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic [3:0] mm = 4'd0;
  logic [3:0] stat = 4'd0;
`ifdef CTRL_STALL_EN
  logic       mem_ready = 1'b1;
`endif
  logic       ir_load, pc_write, br_sel, rf_we, rd_sel, dm_we, halted, wb_sel;
  logic [1:0] alu_op;
  logic [2:0] state;

  int n_vec = 0;
  int n_bad = 0;
  logic [12:0] exp_q[$];

  wire [12:0] obs = {state, ir_load, pc_write, br_sel, rf_we, rd_sel,
                     dm_we, halted, wb_sel, alu_op};

  always #5 clk = ~clk;

  sisc_ctrl #(
    .OPC_W    (4),
    .MM_W     (4),
    .ALU_OP_W (2)
  ) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .opcode    (opcode),
    .mm        (mm),
    .stat      (stat),
`ifdef CTRL_STALL_EN
    .mem_ready (mem_ready),
`endif
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .br_sel    (br_sel),
    .rf_we     (rf_we),
    .rd_sel    (rd_sel),
    .dm_we     (dm_we),
    .halted    (halted),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .state     (state)
  );

  function automatic logic [12:0] ev(input logic [2:0] st, input logic il,
      input logic pw, input logic bs, input logic rw, input logic rs,
      input logic dw, input logic h, input logic wb, input logic [1:0] alu);
    return {st, il, pw, bs, rw, rs, dw, h, wb, alu};
  endfunction

  localparam logic [12:0] V_START  = {3'd0, 10'b0000000000};
  localparam logic [12:0] V_FETCH  = {3'd1, 10'b1100000000};
  localparam logic [12:0] V_DECODE = {3'd2, 10'b0000000000};
  localparam logic [12:0] V_HALT   = {3'd6, 10'b0000001000};

  // Queue the five vectors of one instruction (FETCH and DECODE are fixed).
  task automatic push_instr(input logic [12:0] e, input logic [12:0] m,
                            input logic [12:0] w);
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DECODE);
    exp_q.push_back(e);
    exp_q.push_back(m);
    exp_q.push_back(w);
  endtask

  task automatic test_reset;
    logic [12:0] exp_v;
    rst_f = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_f = 1'b0;
    exp_q.push_back(V_START);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL reset_start: got %b want %b", obs, exp_v);
    end
    @(negedge clk);
    exp_q.push_back(V_FETCH);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL reset_fetch: got %b want %b", obs, exp_v);
    end
    $display("reset: START then FETCH checked");
  endtask

  task automatic test_alu;
    logic [12:0] exp_v;
    for (int k = 0; k < 2; k++) begin
      opcode = 4'd8;
      mm     = (k == 0) ? 4'b1000 : 4'b0000;
      stat   = 4'b1111;
      if (k == 0)
        push_instr(ev(3'd3,0,0,0,0,0,0,0,0,2'd1), ev(3'd4,0,0,0,0,0,0,0,0,2'd1),
                   ev(3'd5,0,0,0,1,0,0,0,0,2'd1));
      else
        push_instr(ev(3'd3,0,0,0,0,0,0,0,0,2'd0), ev(3'd4,0,0,0,0,0,0,0,0,2'd0),
                   ev(3'd5,0,0,0,1,0,0,0,0,2'd0));
      for (int i = 0; exp_q.size() > 0; i++) begin
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL alu[%0d.%0d]: got %b want %b", k, i, obs, exp_v);
        end
        @(negedge clk);
      end
      $display("alu: mm=%b checked", mm);
    end
  endtask

  task automatic test_branch;
    logic [12:0] exp_v;
    logic [3:0]  t_op, t_mm, t_st;
    logic        t_tk;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       {t_op, t_mm, t_st, t_tk} = {4'd4, 4'b0010, 4'b0010, 1'b1};
        1:       {t_op, t_mm, t_st, t_tk} = {4'd4, 4'b0010, 4'b0000, 1'b0};
        2:       {t_op, t_mm, t_st, t_tk} = {4'd6, 4'b0010, 4'b0000, 1'b1};
        3:       {t_op, t_mm, t_st, t_tk} = {4'd4, 4'b0000, 4'b0000, 1'b1};
        4:       {t_op, t_mm, t_st, t_tk} = {4'd6, 4'b0010, 4'b0010, 1'b0};
        5:       {t_op, t_mm, t_st, t_tk} = {4'd5, 4'b1100, 4'b0100, 1'b1};
        6:       {t_op, t_mm, t_st, t_tk} = {4'd7, 4'b0001, 4'b1110, 1'b1};
        default: {t_op, t_mm, t_st, t_tk} = {4'd7, 4'b0011, 4'b0010, 1'b0};
      endcase
      opcode = t_op;
      mm     = t_mm;
      stat   = t_st;
      push_instr(ev(3'd3,0,t_tk,t_tk,0,0,0,0,0,2'd0), ev(3'd4,0,0,0,0,0,0,0,0,2'd0),
                 ev(3'd5,0,0,0,0,0,0,0,0,2'd0));
      for (int i = 0; exp_q.size() > 0; i++) begin
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL branch[%0d.%0d] op=%0d mm=%b stat=%b: got %b want %b",
                   k, i, t_op, t_mm, t_st, obs, exp_v);
        end
        @(negedge clk);
      end
      $display("branch: op=%0d mm=%b stat=%b taken=%0d checked", t_op, t_mm, t_st, t_tk);
    end
  endtask

  task automatic test_lod_str;
    logic [12:0] exp_v;
    for (int k = 0; k < 2; k++) begin
      stat = 4'b0000;
      if (k == 0) begin
        opcode = 4'd1;
        mm     = 4'b1000;
        push_instr(ev(3'd3,0,0,0,0,0,0,0,0,2'd3), ev(3'd4,0,0,0,0,0,0,0,0,2'd3),
                   ev(3'd5,0,0,0,1,0,0,0,1,2'd3));
      end else begin
        opcode = 4'd2;
        mm     = 4'b0000;
        push_instr(ev(3'd3,0,0,0,0,0,0,0,0,2'd2), ev(3'd4,0,0,0,0,0,1,0,0,2'd2),
                   ev(3'd5,0,0,0,0,0,0,0,0,2'd2));
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL ldst[%0d.%0d] op=%0d: got %b want %b", k, i, opcode, obs, exp_v);
        end
        @(negedge clk);
      end
      $display("ldst: op=%0d mm=%b checked", opcode, mm);
    end
  endtask

  task automatic test_swp;
    logic [12:0] exp_v;
    opcode = 4'd3;
    mm     = 4'b0000;
    push_instr(ev(3'd3,0,0,0,0,0,0,0,0,2'd2), ev(3'd4,0,0,0,1,1,0,0,0,2'd2),
               ev(3'd5,0,0,0,1,0,0,0,0,2'd2));
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL swp[%0d]: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk);
    end
    $display("swp: checked");
  endtask

  task automatic test_noop;
    logic [12:0] exp_v;
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 4'd0 : 4'd9;
      mm     = 4'b1111;
      stat   = 4'b1111;
      push_instr(ev(3'd3,0,0,0,0,0,0,0,0,2'd0), ev(3'd4,0,0,0,0,0,0,0,0,2'd0),
                 ev(3'd5,0,0,0,0,0,0,0,0,2'd0));
      for (int i = 0; exp_q.size() > 0; i++) begin
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL noop[%0d.%0d] op=%0d: got %b want %b", k, i, opcode, obs, exp_v);
        end
        @(negedge clk);
      end
      $display("noop: op=%0d checked", opcode);
    end
  endtask

  task automatic test_back_to_back;
    logic [12:0] exp_v;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          opcode = 4'd8; mm = 4'b0000; stat = 4'b0000;
          push_instr(ev(3'd3,0,0,0,0,0,0,0,0,2'd0), ev(3'd4,0,0,0,0,0,0,0,0,2'd0),
                     ev(3'd5,0,0,0,1,0,0,0,0,2'd0));
        end
        1: begin
          opcode = 4'd2; mm = 4'b1000; stat = 4'b0000;
          push_instr(ev(3'd3,0,0,0,0,0,0,0,0,2'd3), ev(3'd4,0,0,0,0,0,1,0,0,2'd3),
                     ev(3'd5,0,0,0,0,0,0,0,0,2'd3));
        end
        default: begin
          opcode = 4'd7; mm = 4'b0100; stat = 4'b1011;
          push_instr(ev(3'd3,0,1,1,0,0,0,0,0,2'd0), ev(3'd4,0,0,0,0,0,0,0,0,2'd0),
                     ev(3'd5,0,0,0,0,0,0,0,0,2'd0));
        end
      endcase
      for (int i = 0; exp_q.size() > 0; i++) begin
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL b2b[%0d.%0d] op=%0d: got %b want %b", k, i, opcode, obs, exp_v);
        end
        @(negedge clk);
      end
      $display("b2b: op=%0d checked", opcode);
    end
  endtask

  task automatic test_reset_mid;
    logic [12:0] exp_v;
    opcode = 4'd8;
    mm     = 4'b1000;
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DECODE);
    exp_q.push_back(ev(3'd3,0,0,0,0,0,0,0,0,2'd1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL rst_mid[%0d]: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk);
    end
    rst_f = 1'b1;
    exp_q.push_back(V_START);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL rst_mid_start: got %b want %b", obs, exp_v);
    end
    rst_f = 1'b0;
    exp_q.push_back(V_FETCH);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL rst_mid_fetch: got %b want %b", obs, exp_v);
    end
    $display("rst_mid: reset from MEM checked");
  endtask

`ifdef CTRL_STALL_EN
  task automatic test_stall;
    logic [12:0] exp_v;
    opcode    = 4'd2;
    mm        = 4'b0000;
    mem_ready = 1'b0;
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DECODE);
    exp_q.push_back(ev(3'd3,0,0,0,0,0,0,0,0,2'd2));
    repeat (4) exp_q.push_back(ev(3'd4,0,0,0,0,0,1,0,0,2'd2));
    exp_q.push_back(ev(3'd5,0,0,0,0,0,0,0,0,2'd2));
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL stall[%0d]: got %b want %b", i, obs, exp_v);
      end
      if (i == 6) mem_ready = 1'b1;
      @(negedge clk);
    end
    $display("stall: STR held 4 cycles in MEM checked");
    mem_ready = 1'b0;
    push_instr(ev(3'd3,0,0,0,0,0,0,0,0,2'd2), ev(3'd4,0,0,0,0,0,1,0,0,2'd2),
               ev(3'd4,0,0,0,0,0,1,0,0,2'd2));
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL stall_rst[%0d]: got %b want %b", i, obs, exp_v);
      end
      @(negedge clk);
    end
    rst_f = 1'b1;
    exp_q.push_back(V_START);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL stall_rst_start: got %b want %b", obs, exp_v);
    end
    rst_f     = 1'b0;
    mem_ready = 1'b1;
    exp_q.push_back(V_FETCH);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL stall_rst_fetch: got %b want %b", obs, exp_v);
    end
    $display("stall: reset during stall checked");
  endtask
`endif

  task automatic test_halt;
    logic [12:0] exp_v;
    opcode = 4'd15;
    mm     = 4'b1111;
    stat   = 4'b1111;
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DECODE);
    repeat (10) exp_q.push_back(V_HALT);
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL halt[%0d]: got %b want %b", i, obs, exp_v);
      end
      if (i == 5) opcode = 4'd0;  // HALT must not depend on the opcode
      @(negedge clk);
    end
    rst_f = 1'b1;
    exp_q.push_back(V_START);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL halt_rst_start: got %b want %b", obs, exp_v);
    end
    rst_f = 1'b0;
    exp_q.push_back(V_FETCH);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL halt_rst_fetch: got %b want %b", obs, exp_v);
    end
    $display("halt: sticky HALT and reset exit checked");
  endtask

  initial begin
    test_reset;
    test_alu;
    test_branch;
    test_lod_str;
    test_swp;
    test_noop;
    test_back_to_back;
    test_reset_mid;
`ifdef CTRL_STALL_EN
    test_stall;
`endif
    test_halt;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
